// File: rtl/eprisc_bus_pkg.sv
// Shared types and constants for the epRISC system-bus arbiter and byte shifter.
package eprisc_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_GAP   = 2'd3
   } state_e;

   localparam logic [1:0] SELECT_IDLE    = 2'b11;
   localparam int         CMD_WRITE_BIT  = 7;
   localparam int         BYTES_PER_XFER = 5;
   localparam logic [2:0] LAST_BYTE      = 3'(BYTES_PER_XFER - 1);

   function automatic logic [7:0] make_cmd(input logic write, input logic [6:0] addr);
      logic [7:0] c;
      c = {1'b0, addr};
      c[CMD_WRITE_BIT] = write;
      return c;
   endfunction

   // Data byte for index 1..4, MSB byte first; reads drive zeros.
   function automatic logic [7:0] xfer_byte(input logic write, input logic [31:0] wdata,
                                            input logic [2:0] idx);
      logic [7:0] b;
      b = 8'h00;
      if (write) begin
         case (idx)
            3'd1:    b = wdata[31:24];
            3'd2:    b = wdata[23:16];
            3'd3:    b = wdata[15:8];
            3'd4:    b = wdata[7:0];
            default: b = 8'h00;
         endcase
      end
      return b;
   endfunction

endpackage

// File: rtl/eprisc_bus_byte_shifter.sv
// One bus byte: clock low for CLKDIV cycles then high for CLKDIV cycles,
// MOSI loaded at the falling edge, MISO captured on the edge that raises the clock.
module eprisc_bus_byte_shifter
#(
   parameter int unsigned CLKDIV = 2
)(
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       load_i,
   input  logic       start_i,
   input  logic       clear_i,
   input  logic [7:0] tx_i,
   input  logic [7:0] miso_i,
   output logic       bus_clk_o,
   output logic [7:0] mosi_o,
   output logic [7:0] rx_o,
   output logic       byte_done_o
);

   localparam logic [7:0] HALF_TC = 8'(CLKDIV - 1);

   logic       busy_q, busy_d;
   logic       bus_clk_q, bus_clk_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] mosi_q, mosi_d;
   logic [7:0] rx_q, rx_d;
   logic       tc;

   assign tc = (cnt_q == 8'd0);

   always_comb begin
      busy_d      = busy_q;
      bus_clk_d   = bus_clk_q;
      cnt_d       = cnt_q;
      mosi_d      = mosi_q;
      rx_d        = rx_q;
      byte_done_o = 1'b0;
      if (busy_q) begin
         if (!bus_clk_q) begin
            if (tc) begin
               bus_clk_d = 1'b1;
               rx_d      = miso_i;
               cnt_d     = HALF_TC;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end else begin
            if (tc) begin
               byte_done_o = 1'b1;
               busy_d      = 1'b0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
      end
      // A start in the done cycle chains the next byte without a gap.
      if (start_i) begin
         busy_d    = 1'b1;
         bus_clk_d = 1'b0;
         cnt_d     = HALF_TC;
      end
      if (load_i) begin
         mosi_d = tx_i;
      end else if (clear_i) begin
         mosi_d = 8'h00;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         busy_q    <= 1'b0;
         bus_clk_q <= 1'b1;
         cnt_q     <= 8'd0;
         mosi_q    <= 8'h00;
         rx_q      <= 8'h00;
      end else begin
         busy_q    <= busy_d;
         bus_clk_q <= bus_clk_d;
         cnt_q     <= cnt_d;
         mosi_q    <= mosi_d;
         rx_q      <= rx_d;
      end
   end

   assign bus_clk_o = bus_clk_q;
   assign mosi_o    = mosi_q;
   assign rx_o      = rx_q;

endmodule

// File: rtl/eprisc_bus_arbiter.sv
// Round-robin arbiter between the core LSU (port 0) and DMA (port 1) for the 8-bit system bus.
// state | meaning
// IDLE  | select idle, arbitrate valid requests
// SETUP | select asserted, clock high, command byte on MOSI
// SHIFT | bytes 0..4 (command, then data MSB byte first)
// GAP   | select idle, done pulse, grant dropped
module eprisc_bus_arbiter
   import eprisc_bus_pkg::*;
#(
   parameter int unsigned CLKDIV = 2
)(
   input  logic        iBoardClock,
   input  logic        iBoardReset,
   input  logic        iReq0,
   input  logic [1:0]  iDev0,
   input  logic        iWrite0,
   input  logic [6:0]  iAddr0,
   input  logic [31:0] iWData0,
   input  logic        iReq1,
   input  logic [1:0]  iDev1,
   input  logic        iWrite1,
   input  logic [6:0]  iAddr1,
   input  logic [31:0] iWData1,
   output logic        oGrant0,
   output logic        oDone0,
   output logic        oGrant1,
   output logic        oDone1,
   output logic [31:0] oRData,
   output logic [0:7]  oBusMOSI,
   input  logic [0:7]  iBusMISO,
   output logic        oBusClock,
   output logic [0:1]  oBusSelect,
   input  logic        iBusInterrupt,
   output logic        oIrq
);

   state_e      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic        owner_q, owner_d;
   logic        last_q, last_d;
   logic        write_q, write_d;
   logic [6:0]  addr_q, addr_d;
   logic [1:0]  dev_q, dev_d;
   logic [31:0] wdata_q, wdata_d;
   logic [23:0] rshift_q, rshift_d;
   logic [31:0] rdata_q, rdata_d;
   logic        irq_meta_q, irq_q;

   logic        valid0, valid1, win;
   logic        win_write;
   logic [6:0]  win_addr;
   logic [1:0]  win_dev;
   logic [31:0] win_wdata;
   logic        sh_load, sh_start, sh_clear, sh_done, sh_clk;
   logic [7:0]  sh_tx, sh_rx, sh_mosi, miso;
   logic        busy;

   assign valid0 = iReq0 && (iDev0 != SELECT_IDLE);
   assign valid1 = iReq1 && (iDev1 != SELECT_IDLE);
   // On a tie the port that was not granted last time wins.
   assign win       = (valid0 && valid1) ? ~last_q : valid1;
   assign win_write = win ? iWrite1 : iWrite0;
   assign win_addr  = win ? iAddr1  : iAddr0;
   assign win_dev   = win ? iDev1   : iDev0;
   assign win_wdata = win ? iWData1 : iWData0;
   assign miso      = iBusMISO;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      owner_d  = owner_q;
      last_d   = last_q;
      write_d  = write_q;
      addr_d   = addr_q;
      dev_d    = dev_q;
      wdata_d  = wdata_q;
      rshift_d = rshift_q;
      rdata_d  = rdata_q;
      sh_load  = 1'b0;
      sh_start = 1'b0;
      sh_clear = 1'b0;
      sh_tx    = 8'h00;
      case (state_q)
         ST_IDLE: begin
            if (valid0 || valid1) begin
               owner_d = win;
               last_d  = win;
               write_d = win_write;
               addr_d  = win_addr;
               dev_d   = win_dev;
               wdata_d = win_wdata;
               sh_tx   = make_cmd(win_write, win_addr);
               sh_load = 1'b1;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            sh_start = 1'b1;
            idx_d    = 3'd0;
            state_d  = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (sh_done) begin
               if (idx_q == LAST_BYTE) begin
                  sh_clear = 1'b1;
                  state_d  = ST_GAP;
                  if (!write_q) begin
                     rdata_d = {rshift_q, sh_rx};
                  end
               end else begin
                  if (idx_q != 3'd0) begin
                     rshift_d = {rshift_q[15:0], sh_rx};
                  end
                  idx_d    = idx_q + 3'd1;
                  sh_tx    = xfer_byte(write_q, wdata_q, idx_q + 3'd1);
                  sh_load  = 1'b1;
                  sh_start = 1'b1;
               end
            end
         end
         ST_GAP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge iBoardClock or negedge iBoardReset) begin
      if (!iBoardReset) begin
         state_q    <= ST_IDLE;
         idx_q      <= 3'd0;
         owner_q    <= 1'b0;
         last_q     <= 1'b1;
         write_q    <= 1'b0;
         addr_q     <= 7'd0;
         dev_q      <= SELECT_IDLE;
         wdata_q    <= 32'd0;
         rshift_q   <= 24'd0;
         rdata_q    <= 32'd0;
         irq_meta_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         write_q    <= write_d;
         addr_q     <= addr_d;
         dev_q      <= dev_d;
         wdata_q    <= wdata_d;
         rshift_q   <= rshift_d;
         rdata_q    <= rdata_d;
         irq_meta_q <= iBusInterrupt;
         irq_q      <= irq_meta_q;
      end
   end

   eprisc_bus_byte_shifter #(.CLKDIV(CLKDIV)) u_shifter (
      .clk_i       (iBoardClock),
      .rst_n_i     (iBoardReset),
      .load_i      (sh_load),
      .start_i     (sh_start),
      .clear_i     (sh_clear),
      .tx_i        (sh_tx),
      .miso_i      (miso),
      .bus_clk_o   (sh_clk),
      .mosi_o      (sh_mosi),
      .rx_o        (sh_rx),
      .byte_done_o (sh_done)
   );

   assign busy       = (state_q == ST_SETUP) || (state_q == ST_SHIFT);
   assign oGrant0    = busy && !owner_q;
   assign oGrant1    = busy && owner_q;
   assign oDone0     = (state_q == ST_GAP) && !owner_q;
   assign oDone1     = (state_q == ST_GAP) && owner_q;
   assign oBusSelect = busy ? dev_q : SELECT_IDLE;
   assign oBusClock  = sh_clk;
   assign oBusMOSI   = sh_mosi;
   assign oRData     = rdata_q;
   assign oIrq       = irq_q;

endmodule

// File: tb/tb_eprisc_bus_arbiter.sv
// Directed bench for eprisc_bus_arbiter: table of single transfers plus
// back-to-back, mid-transfer reset and interrupt synchroniser sequences.
module tb_eprisc_bus_arbiter;

   logic        clk, rst_n;
   logic        iReq0, iWrite0, iReq1, iWrite1;
   logic [1:0]  iDev0, iDev1;
   logic [6:0]  iAddr0, iAddr1;
   logic [31:0] iWData0, iWData1;
   logic        oGrant0, oDone0, oGrant1, oDone1;
   logic [31:0] oRData;
   logic [0:7]  oBusMOSI;
   logic [0:7]  iBusMISO;
   logic        oBusClock;
   logic [0:1]  oBusSelect;
   logic        iBusInterrupt, oIrq;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        req0;
      logic [1:0]  dev0;
      logic        wr0;
      logic [6:0]  addr0;
      logic [31:0] wd0;
      logic        req1;
      logic [1:0]  dev1;
      logic        wr1;
      logic [6:0]  addr1;
      logic [31:0] wd1;
      logic [31:0] miso;
      int          drop_t;
      int          exp_port;
      logic [1:0]  exp_sel;
      logic [7:0]  exp_cmd;
      logic [31:0] exp_data;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[8];

   eprisc_bus_arbiter #(.CLKDIV(2)) dut (
      .iBoardClock   (clk),
      .iBoardReset   (rst_n),
      .iReq0         (iReq0),
      .iDev0         (iDev0),
      .iWrite0       (iWrite0),
      .iAddr0        (iAddr0),
      .iWData0       (iWData0),
      .iReq1         (iReq1),
      .iDev1         (iDev1),
      .iWrite1       (iWrite1),
      .iAddr1        (iAddr1),
      .iWData1       (iWData1),
      .oGrant0       (oGrant0),
      .oDone0        (oDone0),
      .oGrant1       (oGrant1),
      .oDone1        (oDone1),
      .oRData        (oRData),
      .oBusMOSI      (oBusMOSI),
      .iBusMISO      (iBusMISO),
      .oBusClock     (oBusClock),
      .oBusSelect    (oBusSelect),
      .iBusInterrupt (iBusInterrupt),
      .oIrq          (oIrq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drop_all();
      iReq0 = 1'b0;
      iReq1 = 1'b0;
   endtask

   // Called on a negedge while the DUT is idle; that cycle is t=0.
   task automatic run_vec(input vec_t v, input int n);
      int          t, done_t, rises, falls;
      logic        prevclk, other;
      logic [7:0]  mb[5];
      logic [31:0] rd, tmp;
      string       tag;
      tag = $sformatf("v%0d", n);
      iReq0 = v.req0; iDev0 = v.dev0; iWrite0 = v.wr0; iAddr0 = v.addr0; iWData0 = v.wd0;
      iReq1 = v.req1; iDev1 = v.dev1; iWrite1 = v.wr1; iAddr1 = v.addr1; iWData1 = v.wd1;
      iBusMISO = 8'hFF;
      t = 0; done_t = -1; rises = 0; falls = 0; other = 1'b0; prevclk = oBusClock; rd = 32'h0;
      for (int k = 0; k < 5; k++) mb[k] = 8'h00;
      while (done_t < 0 && t < 60) begin
         @(negedge clk);
         t++;
         if (t == 1) begin
            check({tag, "_grant"}, 32'({oGrant1, oGrant0}), (v.exp_port == 1) ? 32'd2 : 32'd1);
            check({tag, "_select"}, 32'(oBusSelect), 32'(v.exp_sel));
         end
         if (t == v.drop_t) begin
            if (v.exp_port == 1) begin
               iReq1 = 1'b0; iWData1 = 32'h0; iAddr1 = 7'h0; iWrite1 = ~v.wr1; iDev1 = 2'd1;
            end else begin
               iReq0 = 1'b0; iWData0 = 32'h0; iAddr0 = 7'h0; iWrite0 = ~v.wr0; iDev0 = 2'd1;
            end
         end
         if (v.exp_port == 1) other |= oGrant0 | oDone0;
         else                 other |= oGrant1 | oDone1;
         if (prevclk && !oBusClock) begin
            tmp = v.miso;
            if (falls >= 1 && falls <= 4) iBusMISO = tmp[(4 - falls) * 8 +: 8];
            else                          iBusMISO = 8'hFF;
            falls++;
         end
         if (!prevclk && oBusClock) begin
            if (rises < 5) mb[rises] = oBusMOSI;
            rises++;
         end
         prevclk = oBusClock;
         if ((v.exp_port == 1) ? oDone1 : oDone0) begin
            done_t = t;
            rd = oRData;
         end
      end
      check({tag, "_done_cycle"}, 32'(done_t), 32'd22);
      check({tag, "_rises"}, 32'(rises), 32'd5);
      check({tag, "_cmd"}, 32'(mb[0]), 32'(v.exp_cmd));
      for (int k = 1; k < 5; k++) begin
         tmp = v.exp_data;
         check($sformatf("%s_byte%0d", tag, k), 32'(mb[k]), 32'(tmp[(4 - k) * 8 +: 8]));
      end
      check({tag, "_rdata"}, rd, v.exp_rdata);
      check({tag, "_other_port"}, 32'(other), 32'd0);
      drop_all();
      @(negedge clk);
      check({tag, "_idle_after"}, 32'({oGrant1, oGrant0, oDone1, oDone0}), 32'd0);
   endtask

   task automatic irq_test(input int width);
      int rise_t, high;
      rise_t = -1; high = 0;
      iBusInterrupt = 1'b1;
      for (int t = 1; t <= width + 6; t++) begin
         @(negedge clk);
         if (t == width) iBusInterrupt = 1'b0;
         if (oIrq) begin
            if (rise_t < 0) rise_t = t;
            high++;
         end
      end
      check($sformatf("irq_latency_w%0d", width), 32'(rise_t >= 2 && rise_t <= 3), 32'd1);
      check($sformatf("irq_width_w%0d", width), 32'(high), 32'(width));
   endtask

   initial begin
      int   t, ng, idle_run;
      int   order[4];
      logic pg0, pg1;
      vec_t vb;

      vecs[0] = '{req0:1'b1, dev0:2'd1, wr0:1'b1, addr0:7'h12, wd0:32'hDEADBEEF,
                  req1:1'b0, dev1:2'd0, wr1:1'b0, addr1:7'h00, wd1:32'h0,
                  miso:32'h0, drop_t:-1, exp_port:0, exp_sel:2'd1, exp_cmd:8'h92,
                  exp_data:32'hDEADBEEF, exp_rdata:32'h0};
      vecs[1] = '{req0:1'b0, dev0:2'd0, wr0:1'b0, addr0:7'h00, wd0:32'h0,
                  req1:1'b1, dev1:2'd2, wr1:1'b0, addr1:7'h05, wd1:32'h0,
                  miso:32'h01234567, drop_t:-1, exp_port:1, exp_sel:2'd2, exp_cmd:8'h05,
                  exp_data:32'h0, exp_rdata:32'h01234567};
      vecs[2] = '{req0:1'b1, dev0:2'd0, wr0:1'b1, addr0:7'h7F, wd0:32'h11223344,
                  req1:1'b1, dev1:2'd2, wr1:1'b1, addr1:7'h01, wd1:32'h55667788,
                  miso:32'h0, drop_t:-1, exp_port:0, exp_sel:2'd0, exp_cmd:8'hFF,
                  exp_data:32'h11223344, exp_rdata:32'h01234567};
      vecs[3] = '{req0:1'b1, dev0:2'd0, wr0:1'b1, addr0:7'h7F, wd0:32'h11223344,
                  req1:1'b1, dev1:2'd2, wr1:1'b1, addr1:7'h01, wd1:32'h55667788,
                  miso:32'h0, drop_t:-1, exp_port:1, exp_sel:2'd2, exp_cmd:8'h81,
                  exp_data:32'h55667788, exp_rdata:32'h01234567};
      vecs[4] = '{req0:1'b1, dev0:2'd3, wr0:1'b1, addr0:7'h11, wd0:32'hFFFFFFFF,
                  req1:1'b1, dev1:2'd0, wr1:1'b0, addr1:7'h40, wd1:32'h0,
                  miso:32'hAABBCCDD, drop_t:-1, exp_port:1, exp_sel:2'd0, exp_cmd:8'h40,
                  exp_data:32'h0, exp_rdata:32'hAABBCCDD};
      vecs[5] = '{req0:1'b1, dev0:2'd2, wr0:1'b0, addr0:7'h33, wd0:32'h0,
                  req1:1'b0, dev1:2'd0, wr1:1'b0, addr1:7'h00, wd1:32'h0,
                  miso:32'h0F1E2D3C, drop_t:-1, exp_port:0, exp_sel:2'd2, exp_cmd:8'h33,
                  exp_data:32'h0, exp_rdata:32'h0F1E2D3C};
      vecs[6] = '{req0:1'b0, dev0:2'd0, wr0:1'b0, addr0:7'h00, wd0:32'h0,
                  req1:1'b1, dev1:2'd1, wr1:1'b1, addr1:7'h00, wd1:32'hCAFEF00D,
                  miso:32'h0, drop_t:-1, exp_port:1, exp_sel:2'd1, exp_cmd:8'h80,
                  exp_data:32'hCAFEF00D, exp_rdata:32'h0F1E2D3C};
      vecs[7] = '{req0:1'b0, dev0:2'd0, wr0:1'b0, addr0:7'h00, wd0:32'h0,
                  req1:1'b1, dev1:2'd0, wr1:1'b1, addr1:7'h2A, wd1:32'h0BADCAFE,
                  miso:32'h0, drop_t:8, exp_port:1, exp_sel:2'd0, exp_cmd:8'hAA,
                  exp_data:32'h0BADCAFE, exp_rdata:32'h0F1E2D3C};

      rst_n = 1'b0;
      iReq0 = 1'b0; iDev0 = 2'd0; iWrite0 = 1'b0; iAddr0 = 7'h0; iWData0 = 32'h0;
      iReq1 = 1'b0; iDev1 = 2'd0; iWrite1 = 1'b0; iAddr1 = 7'h0; iWData1 = 32'h0;
      iBusMISO = 8'h00; iBusInterrupt = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_select", 32'(oBusSelect), 32'd3);
      check("rst_busclk", 32'(oBusClock), 32'd1);
      check("rst_mosi", 32'(oBusMOSI), 32'd0);
      check("rst_grant_done", 32'({oGrant1, oGrant0, oDone1, oDone0}), 32'd0);
      check("rst_rdata", oRData, 32'd0);
      check("rst_irq", 32'(oIrq), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Both ports hold requests: expect alternating grants with two idle-select cycles.
      iReq0 = 1'b1; iDev0 = 2'd1; iWrite0 = 1'b1; iAddr0 = 7'h01; iWData0 = 32'h12345678;
      iReq1 = 1'b1; iDev1 = 2'd2; iWrite1 = 1'b0; iAddr1 = 7'h02; iWData1 = 32'h0;
      for (int i = 0; i < 4; i++) order[i] = -1;
      ng = 0; idle_run = 0; pg0 = 1'b0; pg1 = 1'b0; t = 0;
      while (ng < 4 && t < 200) begin
         @(negedge clk);
         t++;
         if (oGrant0 && !pg0) begin order[ng] = 0; ng++; end
         else if (oGrant1 && !pg1) begin order[ng] = 1; ng++; end
         if (oBusSelect == 2'b11) idle_run++;
         else begin
            if (idle_run > 0) check("b2b_idle_cycles", 32'(idle_run), 32'd2);
            idle_run = 0;
         end
         pg0 = oGrant0; pg1 = oGrant1;
      end
      drop_all();
      check("b2b_grant_count", 32'(ng), 32'd4);
      for (int i = 0; i < 4; i++)
         check($sformatf("b2b_order%0d", i), 32'(order[i]), 32'(i % 2));
      t = 0;
      while (!(oDone0 || oDone1) && t < 40) begin
         @(negedge clk);
         t++;
      end
      check("b2b_final_done", 32'(oDone0 || oDone1), 32'd1);
      @(negedge clk);

      // Reset during byte 2 low phase, then a clean re-request.
      iReq0 = 1'b1; iDev0 = 2'd1; iWrite0 = 1'b1; iAddr0 = 7'h12; iWData0 = 32'h01020304;
      repeat (10) @(negedge clk);
      check("midrst_pre_clk_low", 32'(oBusClock), 32'd0);
      check("midrst_pre_mosi", 32'(oBusMOSI), 32'h02);
      rst_n = 1'b0;
      iReq0 = 1'b0;
      #1;
      check("midrst_select", 32'(oBusSelect), 32'd3);
      check("midrst_busclk", 32'(oBusClock), 32'd1);
      check("midrst_grant_done", 32'({oGrant1, oGrant0, oDone1, oDone0}), 32'd0);
      check("midrst_mosi", 32'(oBusMOSI), 32'd0);
      check("midrst_rdata", oRData, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("midrst_no_done", 32'({oGrant0, oDone0}), 32'd0);
      end
      vb = '{req0:1'b1, dev0:2'd1, wr0:1'b1, addr0:7'h12, wd0:32'h01020304,
             req1:1'b0, dev1:2'd0, wr1:1'b0, addr1:7'h00, wd1:32'h0,
             miso:32'h0, drop_t:-1, exp_port:0, exp_sel:2'd1, exp_cmd:8'h92,
             exp_data:32'h01020304, exp_rdata:32'h0};
      run_vec(vb, 8);

      irq_test(1);
      irq_test(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
